// File: rtl/definitions_pkg.sv
// Shared definitions for the UART frame loader: FSM states, error codes and framing constants.
// Optional checksum support is enabled with the UART_FRAME_CHECKSUM_EN macro.
package definitions_pkg;

    localparam int         OVERSAMPLE        = 16;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
`ifdef UART_FRAME_CHECKSUM_EN
        PAYLOAD = 3'd3,
        CHK     = 3'd4
`else
        PAYLOAD = 3'd3
`endif
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_LEN      = 2'b10,
        ERR_CHECKSUM = 2'b11
    } err_e;

endpackage

// File: rtl/uart_frame_loader_if.sv
// Byte-receive and memory-write bus of the UART frame loader.
// master = the loader (consumes received bytes, issues writes); slave = receiver plus memory.
interface uart_frame_loader_if #(
    parameter int ADDR_W = 16
) ();
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              s_tick;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        input  rx_data, rx_done, s_tick,
        output mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_data, rx_done, s_tick,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout: counts s_tick pulses, cleared by clr; tc fires on the tick that would
// pass the last allowed count, so TIMEOUT_TICKS silent ticks in a row are needed to expire.
module uart_frame_timeout #(
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic clk,
    input  logic rstN,
    input  logic clr,
    input  logic tick,
    output logic tc
);
    localparam int            CW   = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_term_s;

    assign at_term_s = (cnt_q == TERM);
    // clr has priority so a byte arriving on the terminal tick cancels the timeout
    assign tc        = tick && !clr && at_term_s;

    // Next count: clear, advance on tick, wrap at terminal
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = at_term_s ? '0 : cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!rstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_frame_loader.sv
// Parses A5-framed UART byte streams (sync, 16-bit big-endian length, payload[, checksum])
// into memory writes. Checksum stage is present only when UART_FRAME_CHECKSUM_EN is defined.
module uart_frame_loader
    import definitions_pkg::*;
#(
    parameter int         ADDR_W        = 16,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_TICKS = 4096
) (
    input  logic                clk,
    input  logic                rstN,
    uart_frame_loader_if.master bus,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_err,
    output logic [1:0]          err_code
);
    localparam logic [32:0] MAX_LEN = 33'd1 << ADDR_W;

    state_e            state_q, state_d;
    err_e              err_code_q, err_code_d;
    logic              busy_q;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       rem_q, rem_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`else
    // Without a checksum byte, completion is deferred one cycle so it never overlaps mem_we
    logic              done_pend_q, done_pend_d;
`endif

    logic [15:0] rx_len_s;
    logic        len_ovf_s;
    logic        len_zero_s;
    logic        last_s;
    logic        tmo_clr_s;
    logic        timeout_s;

    assign rx_len_s   = {len_hi_q, bus.rx_data};
    assign len_ovf_s  = ({17'd0, rx_len_s} > MAX_LEN);
    assign len_zero_s = (rx_len_s == 16'd0);
    assign last_s     = (rem_q == 16'd1);
    assign tmo_clr_s  = bus.rx_done || (state_q == IDLE);

    uart_frame_timeout #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timeout (
        .clk  (clk),
        .rstN (rstN),
        .clr  (tmo_clr_s),
        .tick (bus.s_tick),
        .tc   (timeout_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: moves only on a received byte or an expired timeout
    always_comb begin
        state_d = state_q;
        if (timeout_s) begin
            state_d = IDLE;
        end else if (bus.rx_done) begin
            case (state_q)
                IDLE:    state_d = (bus.rx_data == SYNC_BYTE) ? LEN_HI : IDLE;
                LEN_HI:  state_d = LEN_LO;
                LEN_LO: begin
                    if (len_ovf_s) begin
                        state_d = IDLE;
                    end else if (len_zero_s) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (last_s) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
`ifdef UART_FRAME_CHECKSUM_EN
                CHK:     state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output and datapath next values
    always_comb begin
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        len_hi_d     = len_hi_q;
        rem_d        = rem_q;
        idx_d        = idx_q;
`ifdef UART_FRAME_CHECKSUM_EN
        frame_done_d = 1'b0;
        sum_d        = sum_q;
`else
        frame_done_d = done_pend_q;
        done_pend_d  = 1'b0;
`endif
        if (timeout_s) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end else if (bus.rx_done) begin
            case (state_q)
                IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        err_code_d = ERR_NONE;
                        idx_d      = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        sum_d      = 8'd0;
`endif
                    end else begin
                        err_code_d = err_code_q;
                    end
                end
                LEN_HI: len_hi_d = bus.rx_data;
                LEN_LO: begin
                    rem_d = rx_len_s;
                    if (len_ovf_s) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
`ifdef UART_FRAME_CHECKSUM_EN
                        err_code_d   = err_code_q;
`else
                        frame_done_d = done_pend_q | len_zero_s;
`endif
                    end
                end
                PAYLOAD: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx_q;
                    mem_wdata_d = bus.rx_data;
                    idx_d       = idx_q + ADDR_W'(1);
                    rem_d       = rem_q - 16'd1;
`ifdef UART_FRAME_CHECKSUM_EN
                    sum_d       = sum_q + bus.rx_data;
`else
                    done_pend_d = last_s;
`endif
                end
`ifdef UART_FRAME_CHECKSUM_EN
                CHK: begin
                    if (bus.rx_data == sum_q) begin
                        frame_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHECKSUM;
                    end
                end
`endif
                default: mem_we_d = 1'b0;
            endcase
        end else begin
            idx_d = idx_q;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!rstN) begin
            busy_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            len_hi_q     <= 8'd0;
            rem_q        <= 16'd0;
            idx_q        <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_q        <= 8'd0;
`else
            done_pend_q  <= 1'b0;
`endif
        end else begin
            busy_q       <= (state_d != IDLE);
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            len_hi_q     <= len_hi_d;
            rem_q        <= rem_d;
            idx_q        <= idx_d;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_q        <= sum_d;
`else
            done_pend_q  <= done_pend_d;
`endif
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign frame_err     = frame_err_q;
    assign err_code      = err_code_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: table of whole frames plus hand sequences for
// timeout, byte-versus-timeout race, length overflow (ADDR_W=4) and mid-frame reset.
module tb_uart_frame_loader;

    localparam int TO = 16;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       busy, frame_done, frame_err;
    logic [1:0] err_code;
    logic       busy4, frame_done4, frame_err4;
    logic [1:0] err_code4;

    uart_frame_loader_if #(.ADDR_W(16)) bus ();
    uart_frame_loader_if #(.ADDR_W(4))  bus4 ();

    uart_frame_loader #(.ADDR_W(16), .SYNC_BYTE(8'hA5), .TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .rstN(rstN), .bus(bus), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
    );

    uart_frame_loader #(.ADDR_W(4), .SYNC_BYTE(8'hA5), .TIMEOUT_TICKS(TO)) dut4 (
        .clk(clk), .rstN(rstN), .bus(bus4), .busy(busy4),
        .frame_done(frame_done4), .frame_err(frame_err4), .err_code(err_code4)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Scoreboard: writes and pulses are accumulated; each test compares deltas from a base.
    logic [31:0] wr_addr_a [0:255];
    logic [31:0] wr_data_a [0:255];
    int          wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int          we4_cnt = 0, done4_cnt = 0, err4_cnt = 0;
    logic [3:0]  last4_addr = 4'd0;
    logic [7:0]  last4_data = 8'd0;
    logic        overlap_seen = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr_a[wr_cnt % 256] <= 32'(bus.mem_addr);
            wr_data_a[wr_cnt % 256] <= 32'(bus.mem_wdata);
            wr_cnt <= wr_cnt + 1;
        end
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (bus4.mem_we === 1'b1) begin
            we4_cnt    <= we4_cnt + 1;
            last4_addr <= bus4.mem_addr;
            last4_data <= bus4.mem_wdata;
        end
        if (frame_done4 === 1'b1) done4_cnt <= done4_cnt + 1;
        if (frame_err4 === 1'b1) err4_cnt <= err4_cnt + 1;
        if ((2'(bus.mem_we === 1'b1) + 2'(frame_done === 1'b1) + 2'(frame_err === 1'b1)) > 2'd1 ||
            (2'(bus4.mem_we === 1'b1) + 2'(frame_done4 === 1'b1) + 2'(frame_err4 === 1'b1)) > 2'd1)
            overlap_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input bit to4, input logic [7:0] b);
        @(negedge clk);
        if (to4) begin
            bus4.rx_data = b;
            bus4.rx_done = 1'b1;
        end else begin
            bus.rx_data = b;
            bus.rx_done = 1'b1;
        end
        @(negedge clk);
        bus.rx_done  = 1'b0;
        bus4.rx_done = 1'b0;
        settle(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.s_tick = 1'b1;
            @(negedge clk);
            bus.s_tick = 1'b0;
        end
        #1;
    endtask

    typedef struct packed {
        logic [3:0]  nbytes;
        logic [63:0] bytes;   // first byte in [63:56]
        logic [2:0]  nwr;
        logic [31:0] wr;      // first written byte in [31:24]
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vt [7];

    initial begin
        int wb, db, eb;
        logic [63:0] bv;
        logic [31:0] wv;

        vt[0] = '{nbytes: 4'd7, bytes: 64'hA5_00_03_11_22_33_66_00, nwr: 3'd3, wr: 32'h11_22_33_00,
                  exp_done: 1'b1, exp_err: 1'b0, exp_code: 2'b00};
        vt[1] = '{nbytes: 4'd6, bytes: 64'h00_FF_A5_00_00_00_00_00, nwr: 3'd0, wr: 32'h0,
                  exp_done: 1'b1, exp_err: 1'b0, exp_code: 2'b00};
        vt[2] = '{nbytes: 4'd6, bytes: 64'hA5_00_02_10_20_00_00_00, nwr: 3'd2, wr: 32'h10_20_00_00,
                  exp_done: !CHK_EN, exp_err: CHK_EN, exp_code: (CHK_EN ? 2'b11 : 2'b00)};
        vt[3] = '{nbytes: 4'd5, bytes: 64'hA5_00_01_FF_FF_00_00_00, nwr: 3'd1, wr: 32'hFF_00_00_00,
                  exp_done: 1'b1, exp_err: 1'b0, exp_code: 2'b00};
        vt[4] = '{nbytes: 4'd6, bytes: 64'hA5_00_02_80_81_01_00_00, nwr: 3'd2, wr: 32'h80_81_00_00,
                  exp_done: 1'b1, exp_err: 1'b0, exp_code: 2'b00};
        vt[5] = '{nbytes: 4'd5, bytes: 64'hA5_00_01_05_06_00_00_00, nwr: 3'd1, wr: 32'h05_00_00_00,
                  exp_done: !CHK_EN, exp_err: CHK_EN, exp_code: (CHK_EN ? 2'b11 : 2'b00)};
        vt[6] = '{nbytes: 4'd6, bytes: 64'hA5_00_02_A5_A5_4A_00_00, nwr: 3'd2, wr: 32'hA5_A5_00_00,
                  exp_done: 1'b1, exp_err: 1'b0, exp_code: 2'b00};

        bus.rx_data = 8'd0;  bus.rx_done = 1'b0;  bus.s_tick = 1'b0;
        bus4.rx_data = 8'd0; bus4.rx_done = 1'b0; bus4.s_tick = 1'b0;
        rstN = 1'b0;
        settle(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        rstN = 1'b1;
        settle(2);

        for (int v = 0; v < 7; v++) begin
            wb = wr_cnt; db = done_cnt; eb = err_cnt;
            bv = vt[v].bytes; wv = vt[v].wr;
            for (int i = 0; i < int'(vt[v].nbytes); i++) send_byte(1'b0, bv[63-8*i -: 8]);
            settle(4);
            check($sformatf("v%0d_nwr", v), 32'(wr_cnt - wb), 32'(vt[v].nwr));
            for (int k = 0; k < int'(vt[v].nwr); k++) begin
                check($sformatf("v%0d_addr%0d", v, k), wr_addr_a[(wb + k) % 256], 32'(k));
                check($sformatf("v%0d_data%0d", v, k), wr_data_a[(wb + k) % 256], 32'(wv[31-8*k -: 8]));
            end
            check($sformatf("v%0d_done", v), 32'(done_cnt - db), 32'(vt[v].exp_done));
            check($sformatf("v%0d_err", v), 32'(err_cnt - eb), 32'(vt[v].exp_err));
            check($sformatf("v%0d_code", v), 32'(err_code), 32'(vt[v].exp_code));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
        end

        // Timeout: TO-1 silent ticks keep the frame alive, the TO-th aborts it
        wb = wr_cnt; eb = err_cnt;
        send_byte(1'b0, 8'hA5); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h04); send_byte(1'b0, 8'h01);
        ticks(TO - 1);
        check("tmo_busy_before", 32'(busy), 32'd1);
        check("tmo_err_before", 32'(err_cnt - eb), 32'd0);
        ticks(1);
        settle(2);
        check("tmo_err", 32'(err_cnt - eb), 32'd1);
        check("tmo_code", 32'(err_code), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_nwr", 32'(wr_cnt - wb), 32'd1);
        check("tmo_addr", wr_addr_a[wb % 256], 32'd0);
        check("tmo_data", wr_data_a[wb % 256], 32'h01);

        // A byte on the terminal tick wins and restarts the count
        wb = wr_cnt; db = done_cnt; eb = err_cnt;
        send_byte(1'b0, 8'hA5); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h02);
        ticks(TO - 1);
        @(negedge clk);
        bus.rx_data = 8'h33; bus.rx_done = 1'b1; bus.s_tick = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0; bus.s_tick = 1'b0;
        settle(2);
        check("race_err", 32'(err_cnt - eb), 32'd0);
        check("race_busy", 32'(busy), 32'd1);
        ticks(TO - 1);
        check("race_busy_after", 32'(busy), 32'd1);
        send_byte(1'b0, 8'h44); send_byte(1'b0, 8'h77);
        settle(2);
        check("race_done", 32'(done_cnt - db), 32'd1);
        check("race_err_end", 32'(err_cnt - eb), 32'd0);
        check("race_nwr", 32'(wr_cnt - wb), 32'd2);
        check("race_data1", wr_data_a[(wb + 1) % 256], 32'h44);

        // Length overflow and the exact-fit boundary on the ADDR_W=4 instance
        eb = err4_cnt; wb = we4_cnt;
        send_byte(1'b1, 8'hA5); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h11);
        settle(2);
        check("ovf_err", 32'(err4_cnt - eb), 32'd1);
        check("ovf_code", 32'(err_code4), 32'd2);
        check("ovf_nwr", 32'(we4_cnt - wb), 32'd0);
        check("ovf_busy", 32'(busy4), 32'd0);
        eb = err4_cnt; wb = we4_cnt; db = done4_cnt;
        send_byte(1'b1, 8'hA5); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h10);
        for (int i = 1; i <= 16; i++) send_byte(1'b1, 8'(i));
        send_byte(1'b1, 8'h88);
        settle(2);
        check("fit_nwr", 32'(we4_cnt - wb), 32'd16);
        check("fit_last_addr", 32'(last4_addr), 32'd15);
        check("fit_last_data", 32'(last4_data), 32'd16);
        check("fit_done", 32'(done4_cnt - db), 32'd1);
        check("fit_err", 32'(err4_cnt - eb), 32'd0);

        // Reset in the middle of a payload
        wb = wr_cnt; db = done_cnt; eb = err_cnt;
        send_byte(1'b0, 8'hA5); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h04);
        send_byte(1'b0, 8'h11); send_byte(1'b0, 8'h22);
        check("mid_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rstN = 1'b0;
        settle(2);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_mem_we", 32'(bus.mem_we), 32'd0);
        check("mid_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("mid_err_code", 32'(err_code), 32'd0);
        rstN = 1'b1;
        settle(3);
        check("mid_no_done", 32'(done_cnt - db), 32'd0);
        check("mid_no_err", 32'(err_cnt - eb), 32'd0);
        check("mid_nwr", 32'(wr_cnt - wb), 32'd2);
        wb = wr_cnt; db = done_cnt;
        send_byte(1'b0, 8'hA5); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h5A); send_byte(1'b0, 8'h5A);
        settle(3);
        check("post_nwr", 32'(wr_cnt - wb), 32'd1);
        check("post_addr", wr_addr_a[wb % 256], 32'd0);
        check("post_data", wr_data_a[wb % 256], 32'h5A);
        check("post_done", 32'(done_cnt - db), 32'd1);

        check("pulse_overlap", 32'(overlap_seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_frame_loader.md
UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

Interface
REQ-001 Parameter ADDR_W, default 16, width of the memory write address.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 Parameter TIMEOUT_TICKS, default 4096, number of s_tick pulses allowed between bytes inside a frame.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rstN  input  1  reset, synchronous, active-low.
REQ-006 rx_data  input  8  received byte, valid when rx_done=1.
REQ-007 rx_done  input  1  one-cycle pulse marking a received byte.
REQ-008 s_tick  input  1  baud-oversample tick used as the timeout timebase.
REQ-009 mem_we  output  1  one-cycle memory write strobe.
REQ-010 mem_addr  output  ADDR_W  write address.
REQ-011 mem_wdata  output  8  write data.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_done  output  1  one-cycle pulse when a frame completes without error.
REQ-014 frame_err  output  1  one-cycle pulse when a frame is aborted.
REQ-015 err_code  output  2  last error: 00 none, 01 timeout, 10 length overflow, 11 checksum mismatch.

Function
REQ-016 FSM states SHALL be IDLE, LEN_HI, LEN_LO, PAYLOAD, CHK; all transitions occur only on rx_done, timeout or reset.
REQ-017 IDLE: rx_done with rx_data==SYNC_BYTE -> LEN_HI and clear err_code; any other byte is discarded and the FSM stays in IDLE.
REQ-018 LEN_HI/LEN_LO: latch the 16-bit big-endian payload length L; after LEN_LO go to PAYLOAD, or to CHK when L==0 (to IDLE with frame_done when L==0 and CHECKSUM_EN is undefined).
REQ-019 If L > 2**ADDR_W: pulse frame_err, set err_code=10, return to IDLE, no memory writes.
REQ-020 PAYLOAD: each rx_done SHALL produce mem_we=1 on the next cycle, with mem_wdata=that byte and mem_addr = payload index (0 for the first byte, +1 per byte).
REQ-021 After payload byte L-1 -> CHK; the running checksum is the 8-bit modulo-256 sum of the payload bytes.
REQ-022 CHK: on rx_done, a byte equal to the running sum pulses frame_done; otherwise frame_err with err_code=11; both cases return to IDLE.
REQ-023 Timeout counter clears on every rx_done and increments on s_tick when the state is not IDLE; reaching TIMEOUT_TICKS-1 pulses frame_err, sets err_code=01 and returns to IDLE.
REQ-024 rx_done and the timeout terminal count in the same cycle: the byte wins and the counter clears.
REQ-025 Bytes already written before an abort are not rolled back; the next frame overwrites memory starting at address 0.
REQ-026 frame_done, frame_err and mem_we SHALL be registered single-cycle pulses, never asserted together.

Reset
REQ-027 rstN=0 on a clock edge -> state IDLE; counters, mem_addr, mem_wdata and checksum cleared; mem_we, busy, frame_done, frame_err and err_code all 0; applies mid-frame with no pulse emitted.

Configuration
REQ-028 Macro UART_FRAME_CHECKSUM_EN defined: CHK state, checksum accumulation and err_code 11 present.
REQ-029 Macro undefined: CHK state and checksum logic absent; after the last payload byte the frame pulses frame_done and returns to IDLE; err_code 11 is never produced.

Structure
REQ-030 The state enum, error-code enum and SYNC_BYTE default SHALL live in definitions_pkg, next to OVERSAMPLE.
REQ-031 One sub-module, uart_frame_timeout (the s_tick counter with clear and terminal-count output), SHALL be instantiated; all other logic is in the top module.

Verification
REQ-032 A5 00 03 11 22 33 66 -> writes 11@0, 22@1, 33@2, then frame_done; err_code=00.
REQ-033 A5 00 02 10 20 00 (CHECKSUM_EN) -> writes 10@0 and 20@1, then frame_err with err_code=11.
REQ-034 A5 00 04 01, then no byte for TIMEOUT_TICKS s_ticks -> frame_err, err_code=01, busy=0, one write at address 0.
REQ-035 ADDR_W=4, A5 00 11 -> frame_err, err_code=10, no mem_we.
REQ-036 Garbage 00 FF, then A5 00 00 00 -> garbage ignored, frame_done with zero writes.
REQ-037 rstN pulsed after the second payload byte -> all outputs 0, no pulse; a following valid frame writes from address 0.
